// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - controller state encoding and entry/address field helpers
package icache_pkg;

   typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FLUSH} state_t;

   // Way entry layout is {valid, tag, data} with valid in the MSB
   function automatic int entry_w(input int tag_w, input int gen_w);
      return 1 + tag_w + gen_w;
   endfunction

   function automatic int entry_tag_lsb(input int gen_w);
      return gen_w;
   endfunction

   function automatic int entry_valid_bit(input int tag_w, input int gen_w);
      return tag_w + gen_w;
   endfunction

   function automatic int addr_tag_lsb(input int off_w, input int set_d);
      return off_w + set_d;
   endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// rtl/icache_victim_sel.sv - one-hot victim way: lowest invalid way, else round-robin pointer
module icache_victim_sel
   import icache_pkg::*;
#(
   parameter int NUM_WAY   = 2,
   parameter int WAY_DEPTH = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_WAY-1:0]   valid_vec,
   input  logic                 advance,
   output logic [NUM_WAY-1:0]   victim_oh
);

   logic [WAY_DEPTH-1:0] rr_ptr;
   logic                 found;

   always_comb begin
      victim_oh = '0;
      found     = 1'b0;
      for (int k = 0; k < NUM_WAY; k++) begin
         if (!valid_vec[k] && !found) begin
            victim_oh[k] = 1'b1;
            found        = 1'b1;
         end
      end
      if (!found)
         victim_oh = NUM_WAY'(1) << rr_ptr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rr_ptr <= '0;
      else if (advance)
         rr_ptr <= (rr_ptr == WAY_DEPTH'(NUM_WAY - 1)) ? '0 : rr_ptr + 1'b1;
   end

endmodule

// File: rtl/icache_array_ctrl.sv
// rtl/icache_array_ctrl.sv - icache lookup, refill and flush controller for the set-associative array
// ICACHE_CTRL_PERF_CNT_EN adds hit/miss performance counters (outputs read 0 otherwise)
module icache_array_ctrl
   import icache_pkg::*;
#(
   parameter int GEN_WIDTH    = 64,
   parameter int TAG_WIDTH    = 20,
   parameter int NUM_SET      = 32,
   parameter int NUM_WAY      = 2,
   parameter int SET_DEPTH    = 5,
   parameter int WAY_DEPTH    = 1,
   parameter int ADDR_WIDTH   = 32,
   parameter int OFFSET_WIDTH = 3,
   localparam int ENTRY_W     = entry_w(TAG_WIDTH, GEN_WIDTH)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          core_req_valid_i,
   output logic                          core_req_ready_o,
   input  logic [ADDR_WIDTH-1:0]         core_req_addr_i,
   output logic                          core_rsp_valid_o,
   output logic [GEN_WIDTH-1:0]          core_rsp_data_o,
   output logic                          core_rsp_hit_o,
   output logic                          mem_req_valid_o,
   input  logic                          mem_req_ready_i,
   output logic [ADDR_WIDTH-1:0]         mem_req_addr_o,
   input  logic                          mem_rsp_valid_i,
   input  logic [GEN_WIDTH-1:0]          mem_rsp_data_i,
   input  logic                          flush_i,
   output logic                          flush_busy_o,
   output logic                          r_req_valid_o,
   output logic [SET_DEPTH-1:0]          r_req_setid_o,
   input  logic [NUM_WAY*ENTRY_W-1:0]    r_resp_data_i,
   output logic                          w_req_valid_o,
   output logic [SET_DEPTH-1:0]          w_req_setid_o,
   output logic [NUM_WAY-1:0]            w_req_waymask_o,
   output logic [NUM_WAY*ENTRY_W-1:0]    w_req_data_o,
   output logic [31:0]                   hit_cnt_o,
   output logic [31:0]                   miss_cnt_o
);

   localparam int TAG_LSB   = addr_tag_lsb(OFFSET_WIDTH, SET_DEPTH);
   localparam int VALID_BIT = entry_valid_bit(TAG_WIDTH, GEN_WIDTH);
   localparam int ETAG_LSB  = entry_tag_lsb(GEN_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_WIDTH) - 1);

   state_t                state;
   logic                  active;
   logic                  flush_pend;
   logic                  accept;
   logic                  hit;
   logic                  lookup_hit;
   logic                  miss_done;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [SET_DEPTH-1:0]  set_cnt;
   logic [SET_DEPTH-1:0]  lat_set;
   logic [TAG_WIDTH-1:0]  lat_tag;
   logic [NUM_WAY-1:0]    way_valid;
   logic [NUM_WAY-1:0]    victim_oh;
   logic [NUM_WAY-1:0]    victim_q;
   logic [ENTRY_W-1:0]    ent;
   logic [GEN_WIDTH-1:0]  hit_data;

   assign lat_set = addr_q[OFFSET_WIDTH +: SET_DEPTH];
   assign lat_tag = addr_q[TAG_LSB +: TAG_WIDTH];

   // Walk ways from the top down so the lowest matching way is the one left standing
   always_comb begin
      way_valid = '0;
      hit       = 1'b0;
      hit_data  = '0;
      ent       = '0;
      for (int k = NUM_WAY - 1; k >= 0; k--) begin
         ent          = r_resp_data_i[ENTRY_W*k +: ENTRY_W];
         way_valid[k] = ent[VALID_BIT];
         if (ent[VALID_BIT] && (ent[ETAG_LSB +: TAG_WIDTH] == lat_tag)) begin
            hit      = 1'b1;
            hit_data = ent[GEN_WIDTH-1:0];
         end
      end
   end

   // active keeps ready low while reset is asserted and for the first cycle after it
   assign core_req_ready_o = active && (state == IDLE) && !flush_pend && !flush_i;
   assign accept           = core_req_valid_i && core_req_ready_o;
   assign r_req_valid_o    = accept;
   assign r_req_setid_o    = accept ? core_req_addr_i[OFFSET_WIDTH +: SET_DEPTH] : '0;
   assign lookup_hit       = (state == LOOKUP) && hit;
   assign miss_done        = (state == MISS_WAIT) && mem_rsp_valid_i;
   assign core_rsp_valid_o = lookup_hit || miss_done;
   assign core_rsp_hit_o   = lookup_hit;
   assign core_rsp_data_o  = lookup_hit ? hit_data : (miss_done ? mem_rsp_data_i : '0);
   assign mem_req_valid_o  = (state == MISS_REQ);
   assign mem_req_addr_o   = addr_q & ~OFFSET_MASK;
   assign flush_busy_o     = flush_pend || (state == FLUSH);

   always_comb begin
      w_req_valid_o   = 1'b0;
      w_req_setid_o   = '0;
      w_req_waymask_o = '0;
      w_req_data_o    = '0;
      if (state == FLUSH) begin
         w_req_valid_o   = 1'b1;
         w_req_setid_o   = set_cnt;
         w_req_waymask_o = '1;
      end else if (miss_done) begin
         w_req_valid_o   = 1'b1;
         w_req_setid_o   = lat_set;
         w_req_waymask_o = victim_q;
         w_req_data_o    = {NUM_WAY{{1'b1, lat_tag, mem_rsp_data_i}}};
      end
   end

   icache_victim_sel #(
      .NUM_WAY   (NUM_WAY),
      .WAY_DEPTH (WAY_DEPTH)
   ) u_victim_sel (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_vec (way_valid),
      .advance   (miss_done),
      .victim_oh (victim_oh)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         active     <= 1'b0;
         flush_pend <= 1'b0;
         addr_q     <= '0;
         set_cnt    <= '0;
         victim_q   <= '0;
      end else begin
         active <= 1'b1;
         if (flush_i && (state != IDLE))
            flush_pend <= 1'b1;
         case (state)
            IDLE: begin
               if (flush_pend || flush_i) begin
                  state   <= FLUSH;
                  set_cnt <= '0;
               end else if (accept) begin
                  addr_q <= core_req_addr_i;
                  state  <= LOOKUP;
               end
            end
            LOOKUP: begin
               victim_q <= victim_oh;
               state    <= hit ? IDLE : MISS_REQ;
            end
            MISS_REQ: begin
               if (mem_req_ready_i)
                  state <= MISS_WAIT;
            end
            MISS_WAIT: begin
               if (mem_rsp_valid_i)
                  state <= IDLE;
            end
            FLUSH: begin
               set_cnt <= set_cnt + 1'b1;
               if (set_cnt == SET_DEPTH'(NUM_SET - 1)) begin
                  state      <= IDLE;
                  flush_pend <= flush_i;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ICACHE_CTRL_PERF_CNT_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (state == LOOKUP) begin
         if (hit)
            hit_cnt_q <= hit_cnt_q + 32'd1;
         else
            miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`else
   assign hit_cnt_o  = '0;
   assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_icache_array_ctrl.sv
// tb/tb_icache_array_ctrl.sv - scoreboard bench for icache_array_ctrl with array and memory models
module tb_icache_array_ctrl;

   localparam int GW = 64;
   localparam int TW = 20;
   localparam int NS = 32;
   localparam int NW = 2;
   localparam int SD = 5;
   localparam int EW = 1 + TW + GW;

   typedef struct packed {
      logic          hit;
      logic [GW-1:0] data;
   } rsp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              core_req_valid_i;
   logic              core_req_ready_o;
   logic [31:0]       core_req_addr_i;
   logic              core_rsp_valid_o;
   logic [GW-1:0]     core_rsp_data_o;
   logic              core_rsp_hit_o;
   logic              mem_req_valid_o;
   logic              mem_req_ready_i;
   logic [31:0]       mem_req_addr_o;
   logic              mem_rsp_valid_i;
   logic [GW-1:0]     mem_rsp_data_i;
   logic              flush_i;
   logic              flush_busy_o;
   logic              r_req_valid_o;
   logic [SD-1:0]     r_req_setid_o;
   logic [NW*EW-1:0]  r_resp_data_i;
   logic              w_req_valid_o;
   logic [SD-1:0]     w_req_setid_o;
   logic [NW-1:0]     w_req_waymask_o;
   logic [NW*EW-1:0]  w_req_data_o;
   logic [31:0]       hit_cnt_o;
   logic [31:0]       miss_cnt_o;

   logic [EW-1:0]     sram [NS][NW];
   logic              poke_en;
   logic [SD-1:0]     poke_set;
   logic [EW-1:0]     poke_w0;
   logic [EW-1:0]     poke_w1;

   rsp_t              sb_q[$];
   rsp_t              mon_e;
   int                errs = 0;
   int                checks = 0;
   int                n_hit = 0;
   int                n_miss = 0;

   always #5 clk = ~clk;

   icache_array_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .core_req_valid_i (core_req_valid_i),
      .core_req_ready_o (core_req_ready_o),
      .core_req_addr_i  (core_req_addr_i),
      .core_rsp_valid_o (core_rsp_valid_o),
      .core_rsp_data_o  (core_rsp_data_o),
      .core_rsp_hit_o   (core_rsp_hit_o),
      .mem_req_valid_o  (mem_req_valid_o),
      .mem_req_ready_i  (mem_req_ready_i),
      .mem_req_addr_o   (mem_req_addr_o),
      .mem_rsp_valid_i  (mem_rsp_valid_i),
      .mem_rsp_data_i   (mem_rsp_data_i),
      .flush_i          (flush_i),
      .flush_busy_o     (flush_busy_o),
      .r_req_valid_o    (r_req_valid_o),
      .r_req_setid_o    (r_req_setid_o),
      .r_resp_data_i    (r_resp_data_i),
      .w_req_valid_o    (w_req_valid_o),
      .w_req_setid_o    (w_req_setid_o),
      .w_req_waymask_o  (w_req_waymask_o),
      .w_req_data_o     (w_req_data_o),
      .hit_cnt_o        (hit_cnt_o),
      .miss_cnt_o       (miss_cnt_o)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [GW-1:0] mem_data(input logic [31:0] a);
      return {a ^ 32'hA5A5_0000, ~a};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Array macro model: synchronous read with one-cycle latency, masked write
   always @(posedge clk) begin
      if (r_req_valid_o)
         for (int k = 0; k < NW; k++)
            r_resp_data_i[EW*k +: EW] <= sram[r_req_setid_o][k];
      if (w_req_valid_o)
         for (int k = 0; k < NW; k++)
            if (w_req_waymask_o[k])
               sram[w_req_setid_o][k] <= w_req_data_o[EW*k +: EW];
      if (poke_en) begin
         sram[poke_set][0] <= poke_w0;
         sram[poke_set][1] <= poke_w1;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (core_rsp_valid_o) begin
            if (sb_q.size() == 0) begin
               chk("rsp_spurious", 1'b1, 1'b0);
            end else begin
               mon_e = sb_q.pop_front();
               chk("rsp_hit", core_rsp_hit_o, mon_e.hit);
               chk("rsp_data", core_rsp_data_o, mon_e.data);
            end
         end
         if (w_req_valid_o)
            chk("rw_excl", r_req_valid_o, 1'b0);
      end
   end

   task automatic do_read(input logic [31:0] addr, input logic exp_hit, input int exp_way,
                          input int rdy_dly, input int rsp_dly, input logic flush_in_wait);
      logic [31:0]   line;
      logic [SD-1:0] set;
      logic [TW-1:0] tag;
      logic [GW-1:0] d;
      int            n;
      line = {addr[31:3], 3'b000};
      set  = addr[7:3];
      tag  = addr[27:8];
      d    = mem_data(line);
      sb_q.push_back({exp_hit, d});
      if (exp_hit) n_hit++; else n_miss++;
      core_req_valid_i = 1'b1;
      core_req_addr_i  = addr;
      #1;
      n = 0;
      while (!core_req_ready_o && n < 50) begin
         tick();
         n++;
      end
      chk("req_ready", core_req_ready_o, 1'b1);
      chk("rd_setid", {r_req_valid_o, r_req_setid_o}, {1'b1, set});
      tick();
      core_req_valid_i = 1'b0;
      #1;
      chk("lookup_rsp", core_rsp_valid_o, exp_hit);
      if (!exp_hit) begin
         tick();
         for (int i = 0; i < rdy_dly; i++) begin
            chk("mreq_hold", {mem_req_valid_o, mem_req_addr_o, core_req_ready_o}, {1'b1, line, 1'b0});
            tick();
         end
         mem_req_ready_i = 1'b1;
         #1;
         chk("mreq", {mem_req_valid_o, mem_req_addr_o}, {1'b1, line});
         tick();
         mem_req_ready_i = 1'b0;
         for (int i = 0; i < rsp_dly; i++) begin
            flush_i = flush_in_wait && (i == 0);
            #1;
            chk("wait_idle", {core_rsp_valid_o, w_req_valid_o, mem_req_valid_o}, 3'b000);
            tick();
         end
         flush_i         = 1'b0;
         mem_rsp_valid_i = 1'b1;
         mem_rsp_data_i  = d;
         #1;
         chk("refill_wr", {w_req_valid_o, w_req_setid_o, w_req_waymask_o}, {1'b1, set, 2'(1 << exp_way)});
         chk("refill_ent", w_req_data_o[EW*exp_way +: EW], {1'b1, tag, d});
         tick();
         mem_rsp_valid_i = 1'b0;
         mem_rsp_data_i  = '0;
      end
   endtask

   task automatic flush_walk();
      int n;
      n = 0;
      while (!w_req_valid_o && n < 10) begin
         tick();
         n++;
      end
      chk("flush_busy", flush_busy_o, 1'b1);
      for (int s = 0; s < NS; s++) begin
         chk("flush_wr", {w_req_valid_o, w_req_setid_o, w_req_waymask_o, core_req_ready_o},
             {1'b1, 5'(s), 2'b11, 1'b0});
         chk("flush_data", w_req_data_o, '0);
         tick();
      end
      chk("flush_done", {flush_busy_o, w_req_valid_o}, 2'b00);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n            = 1'b0;
      core_req_valid_i = 1'b1;
      core_req_addr_i  = 32'h0000_1008;
      mem_req_ready_i  = 1'b0;
      mem_rsp_valid_i  = 1'b0;
      mem_rsp_data_i   = '0;
      flush_i          = 1'b0;
      poke_en          = 1'b0;
      poke_set         = '0;
      poke_w0          = '0;
      poke_w1          = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", {core_req_ready_o, core_rsp_valid_o, core_rsp_hit_o, core_rsp_data_o,
                       mem_req_valid_o, mem_req_addr_o, flush_busy_o, r_req_valid_o,
                       r_req_setid_o, w_req_valid_o, w_req_setid_o, w_req_waymask_o}, '0);
      chk("rst_wdata", w_req_data_o, '0);
      chk("rst_cnt", {hit_cnt_o, miss_cnt_o}, '0);
      core_req_valid_i = 1'b0;
      rst_n = 1'b1;
      tick();
      tick();

      flush_i = 1'b1;
      #1;
      chk("flush_blocks_req", core_req_ready_o, 1'b0);
      tick();
      flush_i = 1'b0;
      flush_walk();

      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = 64'hDEAD_BEEF_0000_0001;
      #1;
      chk("mrsp_ignored", {core_rsp_valid_o, w_req_valid_o}, 2'b00);
      tick();
      mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i  = '0;

      // addr, hit, victim way, ready delay, response delay, flush during wait
      do_read(32'h0000_1008, 1'b0, 0, 0, 1, 1'b0);
      do_read(32'h0000_1008, 1'b1, 0, 0, 0, 1'b0);
      do_read(32'h0000_2008, 1'b0, 1, 0, 0, 1'b0);
      do_read(32'h0000_3008, 1'b0, 0, 0, 0, 1'b0);
      do_read(32'h0000_2008, 1'b1, 0, 0, 0, 1'b0);
      do_read(32'h0000_1008, 1'b0, 1, 0, 0, 1'b0);
      do_read(32'h0000_4010, 1'b0, 0, 5, 0, 1'b0);
      do_read(32'h0000_4014, 1'b1, 0, 0, 0, 1'b0);
      do_read(32'h0000_5018, 1'b0, 0, 0, 2, 1'b1);
      flush_walk();
      do_read(32'h0000_5018, 1'b0, 0, 0, 1, 1'b0);
      do_read(32'h0000_5018, 1'b1, 0, 0, 0, 1'b0);

      // Duplicate tag in both ways of set 6: way 0 must supply the data
      poke_en  = 1'b1;
      poke_set = 5'd6;
      poke_w0  = {1'b1, 20'h00077, mem_data(32'h0000_7730)};
      poke_w1  = {1'b1, 20'h00077, ~mem_data(32'h0000_7730)};
      tick();
      poke_en = 1'b0;
      do_read(32'h0000_7730, 1'b1, 0, 0, 0, 1'b0);

      tick();
      tick();
`ifdef ICACHE_CTRL_PERF_CNT_EN
      chk("hit_cnt", hit_cnt_o, 32'(n_hit));
      chk("miss_cnt", miss_cnt_o, 32'(n_miss));
`else
      chk("hit_cnt", hit_cnt_o, 32'd0);
      chk("miss_cnt", miss_cnt_o, 32'd0);
`endif
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
